// File: rtl/add_seq_arbiter.sv
// add_seq_arbiter: round-robin arbiter feeding one 8-bit ripple slice.
// Sequences a WIDTH-bit add/sub one byte per beat, result on valid/ready.

module rca_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] c;

  // Bit-serial ripple carry through the byte
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

module add_seq_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_id
);

  localparam int N  = WIDTH / 8;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             carry_q, carry_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic       grant0;
  logic       grant1;
  logic       idle;
  logic       done;
  logic       last_beat;
  logic [7:0] slice_a;
  logic [7:0] slice_b;
  logic [7:0] slice_s;
  logic       slice_cout;

  assign idle      = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign last_beat = (beat_q == BW'(N - 1));

  // Round-robin grant; tie goes to the requester not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (idle && rst_n) begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Select the current operand byte from the latched registers
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < N; k++) begin
      if (beat_q == BW'(k)) begin
        slice_a = a_q[8*k +: 8];
        slice_b = b_q[8*k +: 8];
      end
    end
  end

  rca_8 u_rca (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Next-state: accept in IDLE, one byte per RUN beat, hold in DONE
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          a_d          = req0_a;
          b_d          = req0_sub ? ~req0_b : req0_b;
          carry_d      = req0_sub;
          beat_d       = '0;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = RUN;
        end else if (grant1) begin
          a_d          = req1_a;
          b_d          = req1_sub ? ~req1_b : req1_b;
          carry_d      = req1_sub;
          beat_d       = '0;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (beat_q == BW'(k)) begin
            sum_d[8*k +: 8] = slice_s;
          end
        end
        carry_d = slice_cout;
        if (last_beat) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
    end
  end

  // Response fields only show register contents while DONE
  always_comb begin
    rsp_valid = done;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    rsp_ovf   = 1'b0;
    rsp_zero  = 1'b0;
    rsp_id    = 1'b0;
    if (done) begin
      rsp_sum  = sum_q;
      rsp_cout = carry_q;
      rsp_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (sum_q[WIDTH-1] != a_q[WIDTH-1]);
      rsp_zero = ~|sum_q;
      rsp_id   = id_q;
    end
  end

endmodule

// File: tb/tb_add_seq_arbiter.sv
// tb_add_seq_arbiter: directed stimulus, queue scoreboard, negedge monitor.
// Expected responses are hand-computed and pushed before each request.

module tb_add_seq_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_ovf, rsp_zero, rsp_id;

  typedef struct packed {
    logic         id;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] sum;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  add_seq_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push(input logic [W-1:0] sum, input logic cout,
                      input logic ovf, input logic zero, input logic id);
    rsp_t e;
    e.id = id; e.cout = cout; e.ovf = ovf; e.zero = zero; e.sum = sum;
    exp_q.push_back(e);
  endtask

  // Drive one request and hold it until its ready is seen
  task automatic issue(input logic id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sub);
    logic ok;
    @(posedge clk); #1;
    if (id) begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 64'(ok), 64'd1);
  endtask

  // Monitor: handshake scoreboard, ready rules, latency, stability
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W+3:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        acc_cyc = cyc + 1;
        check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
      end
      if (rsp_valid) begin
        check("ready_in_done", 64'(req0_ready | req1_ready), 64'd0);
        if (!prev_valid)
          check("latency", 64'(cyc - acc_cyc), 64'd4);
        else if (!prev_ready)
          check("bp_stable", 64'({rsp_id, rsp_cout, rsp_ovf, rsp_zero,
                                  rsp_sum}), 64'(held));
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 64'(rsp_sum), 64'hDEAD);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp", 64'({rsp_id, rsp_cout, rsp_ovf, rsp_zero,
                             rsp_sum}), 64'(e));
          end
        end
      end
      held = {rsp_id, rsp_cout, rsp_ovf, rsp_zero, rsp_sum};
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
    end
  end

  initial begin
    int n_acc;
    logic ok;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    #22;
    check("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_zero,
                         rsp_sum}), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 rst_n = 1'b1;

    // Fairness: both held high, expect 0,1,0,1
    push(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    push(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    req0_a = 32'd1;  req0_b = 32'd2; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 32'd10; req1_b = 32'd3; req1_sub = 1'b1; req1_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 100 && n_acc < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) n_acc++;
    end
    check("fair_accepts", 64'(n_acc), 64'd4);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Directed add/sub vectors
    push(32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_idle();
    push(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_idle();
    push(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_idle();
    push(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1);
    wait_idle();

    // Backpressure with req1 waiting
    rsp_ready = 1'b0;
    push(32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    req1_a = 32'h0000_0100; req1_b = 32'h0000_0001; req1_sub = 1'b1;
    req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_rsp_timeout", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req1_ready", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_req1_accept", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset during RUN beat 2, operation discarded
    issue(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_ovf,
                             rsp_zero, rsp_sum}), 64'd0);
    check("mid_rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    req1_valid = 1'b0;
    #10 rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    check("no_stale_rsp", 64'(ok), 64'd0);
    push(32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'd3, 32'd4, 1'b0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_seq_arbiter.md
# add_seq_arbiter

Multi-cycle add/subtract controller that time-shares one 8-bit ripple-carry adder slice (RCA_8) between two requesters. It arbitrates round-robin, then sequences a WIDTH-bit add or subtract through the slice one byte per cycle, carrying between beats in a register. It returns the result and flags on a valid/ready response port. It sits in the execute stage wherever a full-width adder is too costly in area and multi-cycle latency is acceptable.

## Interface
- WIDTH, 32: operand width; must be a multiple of 8, minimum 8. Beat count N = WIDTH/8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  operands of requester 0.
- req0_sub  in  1  1 = a − b, 0 = a + b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  WIDTH  result.
- rsp_cout  out  1  carry out of the MSB (for subtract, 1 = no borrow).
- rsp_ovf  out  1  signed overflow.
- rsp_zero  out  1  rsp_sum == 0.
- rsp_id  out  1  index of the requester that owns the result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, arbitration:
  - If exactly one reqX_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - last_grant resets to 1, so req0 wins the first tie.
- IDLE, accept:
  - The grant drives reqX_ready = 1 combinationally in the same cycle.
  - On that edge the block latches a and b_eff = sub ? ~b : b, sets carry = sub, beat = 0, owner id = X, last_grant = X.
  - It then moves to RUN.
- Ready rules: at most one reqX_ready is high per cycle, and never outside IDLE. Requesters hold valid and operands stable until ready is seen.
- RUN, per beat k (k = 0..N−1):
  - The slice computes a[8k+7:8k] + b_eff[8k+7:8k] + carry.
  - The result byte is written to sum[8k+7:8k] and carry takes the slice cout.
  - beat increments; after beat N−1 the FSM moves to DONE.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout (= final carry) and rsp_id come from registers.
  - rsp_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - rsp_zero = ~|sum.
  - If rsp_ready = 1 on an edge, the FSM returns to IDLE. There is no accept in the DONE cycle.
- The slice inputs are driven by muxing latched operand bytes by beat. There is no combinational path from the req ports to the slice.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state IDLE, beat 0, carry 0, last_grant 1, sum/a/b_eff 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, rsp_zero 0, rsp_id 0.
- reqX_ready is combinational, so it reads 0 during reset only because the FSM is held in IDLE with both valids ignored.
  - Requirement: reqX_ready = 0 while rst_n = 0.
- Latency: accept edge at T; RUN beats occupy edges T+1..T+N; rsp_valid rises after edge T+N, i.e. N cycles after accept (4 for WIDTH=32).
- Throughput: at most one operation per N+2 cycles (accept, N beats, one DONE cycle with rsp_ready = 1).
- Backpressure: while rsp_ready = 0 in DONE, all rsp_* outputs stay stable and both reqX_ready stay 0. rsp_valid never drops without a handshake.
- Requests arriving during RUN or DONE wait; the arbiter samples them only in IDLE.
- Reset mid-operation (RUN or DONE): the in-flight operation is discarded with no response, and the block restarts in IDLE after rst_n deasserts.
- WIDTH = 8: N = 1; one RUN cycle.

## Test plan
- Single add, WIDTH=32: req0 with a=0x000000FF, b=0x00000001, add → rsp_sum=0x00000100, cout=0, ovf=0, zero=0, id=0, rsp_valid exactly 4 cycles after req0_ready.
- Full-carry chain: a=0xFFFFFFFF, b=0x00000001, add → sum=0x00000000, cout=1, zero=1, ovf=0. This exercises the carry across all 4 beats.
- Subtract with overflow: req1, a=0x80000000, b=0x00000001, sub → sum=0x7FFFFFFF, cout=1, ovf=1, id=1. Also a=0x00000005, b=0x00000007, sub → sum=0xFFFFFFFE, cout=0, ovf=0.
- Fairness: req0_valid and req1_valid held high continuously with rsp_ready=1 → grant order 0,1,0,1 after reset; never two readies in one cycle.
- Backpressure: rsp_ready held 0 for 5 cycles in DONE with req1_valid high → rsp_* stable, req1_ready=0 throughout. After rsp_ready=1, req1 is accepted in the following IDLE cycle.
- Reset during RUN beat 2: assert rst_n=0 → rsp_valid=0 and all outputs at reset values immediately. After release, no stale response appears; a new add 3+4 returns 7.
